// File: rtl/packet_arbiter36_x3_if.sv
// fifo36 stream: data[32] SOF, data[33] EOF, data[35:34] occupancy.
// The source drives data/valid and the sink drives ready.
interface packet_arbiter36_x3_if;
    logic [35:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/packet_arbiter36_x3.sv
// Packet-granular 3:1 fifo36 arbiter (round-robin or strict priority)
// with a programmable enable mask and packet/drop counters.
module packet_arbiter36_x3 #(
    parameter int         BASE     = 0,
    parameter logic [2:0] EN_RESET = 3'b111
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    packet_arbiter36_x3_if.slave         inp0,
    packet_arbiter36_x3_if.slave         inp1,
    packet_arbiter36_x3_if.slave         inp2,
    packet_arbiter36_x3_if.master        outp,
    output logic [1:0]                   grant,
    output logic [15:0]                  pkt_count,
    output logic [15:0]                  drop_count
);
    localparam logic [7:0] CTRL_ADDR = 8'(BASE);
    localparam logic [7:0] CLR_ADDR  = 8'(BASE + 1);

    typedef enum logic {IDLE, PASS} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_q, last_d;
    logic [2:0]  mask_q, mask_d;
    logic        strict_q, strict_d;
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] drop_q, drop_d;

    logic [2:0][35:0] in_data;
    logic [2:0]       in_valid, in_ready, cand, orphan;
    logic [35:0]      out_data;
    logic             out_valid;
    logic [1:0]       pick, n_drop;
    logic             pick_ok;
    logic [16:0]      drop_sum;
    logic             unused_set_bits;

    assign in_data  = {inp2.data, inp1.data, inp0.data};
    assign in_valid = {inp2.valid, inp1.valid, inp0.valid};
    assign inp0.ready = in_ready[0];
    assign inp1.ready = in_ready[1];
    assign inp2.ready = in_ready[2];
    assign outp.data  = out_data;
    assign outp.valid = out_valid;
    assign grant      = grant_q;
    assign pkt_count  = pkt_q;
    assign drop_count = drop_q;
    assign unused_set_bits = ^{set_data[31:9], set_data[7:3]};

    // SOF beats start a packet; non-SOF beats seen while idle are orphans.
    assign cand   = in_valid & mask_q & {in_data[2][32], in_data[1][32], in_data[0][32]};
    assign orphan = in_valid & mask_q & ~{in_data[2][32], in_data[1][32], in_data[0][32]};

    function automatic logic [1:0] rr_idx(input logic [1:0] l, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, l} + {1'b0, k};
        if (s >= 3'd3) s = s - 3'd3;
        return s[1:0];
    endfunction

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        mask_d    = mask_q;
        strict_d  = strict_q;
        pkt_d     = pkt_q;
        drop_d    = drop_q;
        out_data  = '0;
        out_valid = 1'b0;
        in_ready  = '0;
        pick      = 2'd0;
        pick_ok   = 1'b0;
        n_drop    = 2'd0;
        drop_sum  = '0;
        unique case (state_q)
            IDLE: begin
                for (int i = 0; i < 3; i++) begin
                    if (orphan[i]) begin
                        in_ready[i] = 1'b1;
                        n_drop      = n_drop + 2'd1;
                    end
                end
                // Loops run from lowest priority upward so the last hit wins.
                if (strict_q) begin
                    for (int i = 2; i >= 0; i--) begin
                        if (cand[i]) begin
                            pick_ok = 1'b1;
                            pick    = 2'(i);
                        end
                    end
                end else begin
                    for (int k = 3; k >= 1; k--) begin
                        if (cand[rr_idx(last_q, 2'(k))]) begin
                            pick_ok = 1'b1;
                            pick    = rr_idx(last_q, 2'(k));
                        end
                    end
                end
                if (pick_ok) begin
                    state_d = PASS;
                    grant_d = pick;
                end
                drop_sum = {1'b0, drop_q} + {15'd0, n_drop};
                drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            PASS: begin
                for (int i = 0; i < 3; i++) begin
                    if (grant_q == 2'(i)) begin
                        out_data    = in_data[i];
                        out_valid   = in_valid[i];
                        in_ready[i] = outp.ready;
                    end
                end
                if (out_valid && outp.ready && out_data[33]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    grant_d = 2'd3;
                    pkt_d   = pkt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (set_stb && set_addr == CTRL_ADDR) begin
            mask_d   = set_data[2:0];
            strict_d = set_data[8];
        end
        // Clearing after the increments above makes the clear win.
        if (set_stb && set_addr == CLR_ADDR) begin
            pkt_d  = '0;
            drop_d = '0;
        end
        if (clr) begin
            state_d = IDLE;
            grant_d = 2'd3;
            last_d  = 2'd2;
        end
        if (rst) begin
            in_ready  = '0;
            out_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= 2'd3;
            last_q   <= 2'd2;
            mask_q   <= EN_RESET;
            strict_q <= 1'b0;
            pkt_q    <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            mask_q   <= mask_d;
            strict_q <= strict_d;
            pkt_q    <= pkt_d;
            drop_q   <= drop_d;
        end
    end
endmodule

// File: tb/tb_packet_arbiter36_x3.sv
// Directed bench for packet_arbiter36_x3: a per-cycle behavioural model
// plus literal checks on grant order, beat contents and counters.
module tb_packet_arbiter36_x3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [1:0]  grant;
    logic [15:0] pkt_count, drop_count;

    packet_arbiter36_x3_if inp0();
    packet_arbiter36_x3_if inp1();
    packet_arbiter36_x3_if inp2();
    packet_arbiter36_x3_if outp();

    packet_arbiter36_x3 dut (
        .clk(clk), .rst(rst), .clr(clr),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .inp0(inp0), .inp1(inp1), .inp2(inp2), .outp(outp),
        .grant(grant), .pkt_count(pkt_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    logic [35:0] src_d [3];
    logic        src_v [3];
    logic        fire  [3];
    logic        toggle_rdy = 1'b0;
    logic [35:0] q0[$], q1[$], q2[$];
    logic [35:0] outq[$];
    logic [1:0]  gorder[$];
    int tests = 0;
    int fails = 0;
    int busy  = 0;

    assign inp0.data = src_d[0]; assign inp0.valid = src_v[0];
    assign inp1.data = src_d[1]; assign inp1.valid = src_v[1];
    assign inp2.data = src_d[2]; assign inp2.valid = src_v[2];

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] beat(input bit sof, input bit eof, input logic [31:0] p);
        return {2'b00, eof, sof, p};
    endfunction

    task automatic push_pkt(input int ch, input int n, input logic [31:0] base);
        for (int b = 0; b < n; b++) begin
            logic [35:0] d;
            d = beat(b == 0, b == n - 1, base + 32'(b));
            if (ch == 0) q0.push_back(d);
            else if (ch == 1) q1.push_back(d);
            else q2.push_back(d);
        end
    endtask

    // Sources present the head of their queue and pop on an accepted beat.
    initial begin
        for (int i = 0; i < 3; i++) begin src_v[i] = 1'b0; src_d[i] = '0; fire[i] = 1'b0; end
        outp.ready = 1'b1;
    end
    always @(posedge clk) begin
        #1;
        if (fire[0] && q0.size() != 0) void'(q0.pop_front());
        if (fire[1] && q1.size() != 0) void'(q1.pop_front());
        if (fire[2] && q2.size() != 0) void'(q2.pop_front());
        src_v[0] = q0.size() != 0; src_d[0] = (q0.size() != 0) ? q0[0] : '0;
        src_v[1] = q1.size() != 0; src_d[1] = (q1.size() != 0) ? q1[0] : '0;
        src_v[2] = q2.size() != 0; src_d[2] = (q2.size() != 0) ? q2[0] : '0;
        outp.ready = toggle_rdy ? ~outp.ready : 1'b1;
    end

    // Behavioural model: owner (-1 = none), last winner, registers, counters.
    int   mown, mlast, mpkt, mdrop;
    logic [2:0] mmask;
    logic mstrict;
    bit   minit = 1'b0;
    logic [1:0] prev_g = 2'd3;

    function automatic bit is_cand(input int j);
        return src_v[j] && mmask[j] && src_d[j][32];
    endfunction

    always @(negedge clk) begin
        logic [2:0]  rdy, er;
        logic        ev;
        logic [35:0] ed;
        logic [1:0]  eg;
        int nd, pick;
        rdy = {inp2.ready, inp1.ready, inp0.ready};
        for (int i = 0; i < 3; i++) fire[i] = src_v[i] && rdy[i];
        if (rst) begin
            if (minit) begin
                chk("rst_ready", 36'(rdy), 36'd0);
                chk("rst_out_valid", 36'(outp.valid), 36'd0);
            end
            mown = -1; mlast = 2; mpkt = 0; mdrop = 0; mmask = 3'b111; mstrict = 1'b0;
            minit = 1'b1;
            prev_g = 2'd3;
        end else if (minit) begin
            if (outp.valid && outp.ready) outq.push_back(outp.data);
            if (grant != 2'd3 && prev_g == 2'd3) gorder.push_back(grant);
            prev_g = grant;
            if (src_v[0] || src_v[1] || src_v[2] || grant != 2'd3) busy++;
            er = '0; ev = 1'b0; ed = '0; eg = 2'd3; nd = 0; pick = -1;
            if (mown < 0) begin
                for (int i = 0; i < 3; i++)
                    if (src_v[i] && mmask[i] && !src_d[i][32]) begin er[i] = 1'b1; nd++; end
                if (mstrict) begin
                    for (int i = 2; i >= 0; i--) if (is_cand(i)) pick = i;
                end else begin
                    for (int k = 3; k >= 1; k--) if (is_cand((mlast + k) % 3)) pick = (mlast + k) % 3;
                end
            end else begin
                eg = 2'(mown); ev = src_v[mown]; ed = src_d[mown]; er[mown] = outp.ready;
            end
            chk("grant", 36'(grant), 36'(eg));
            chk("ready", 36'(rdy), 36'(er));
            chk("out_valid", 36'(outp.valid), 36'(ev));
            if (ev) chk("out_data", outp.data, ed);
            chk("pkt_count", 36'(pkt_count), 36'(mpkt));
            chk("drop_count", 36'(drop_count), 36'(mdrop));
            if (mown < 0) begin
                mdrop = (mdrop + nd > 65535) ? 65535 : mdrop + nd;
                if (pick >= 0) mown = pick;
            end else if (ev && outp.ready && src_d[mown][33]) begin
                mlast = mown; mown = -1; mpkt = (mpkt + 1) % 65536;
            end
            if (set_stb && set_addr == 8'd0) begin mmask = set_data[2:0]; mstrict = set_data[8]; end
            if (set_stb && set_addr == 8'd1) begin mpkt = 0; mdrop = 0; end
            if (clr) begin mown = -1; mlast = 2; end
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1 set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1 set_stb = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit ign0);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if ((ign0 || (q0.size() == 0 && !src_v[0])) && q1.size() == 0 && q2.size() == 0 &&
                !src_v[1] && !src_v[2] && grant == 2'd3) ok = 1'b1;
        end
        if (!ok) begin tests++; fails++; $display("FAIL %s: timeout waiting for idle", nm); end
    endtask

    task automatic chk_order(input string nm, input logic [1:0] e0, input logic [1:0] e1,
                             input logic [1:0] e2, input int n);
        logic [1:0] e [3];
        e[0] = e0; e[1] = e1; e[2] = e2;
        chk({nm, "_len"}, 36'(gorder.size()), 36'(n));
        for (int i = 0; i < n && i < gorder.size(); i++) chk(nm, 36'(gorder[i]), 36'(e[i % 3]));
    endtask

    initial begin
        int b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_grant", 36'(grant), 36'd3);
        chk("reset_pkt", 36'(pkt_count), 36'd0);
        chk("reset_drop", 36'(drop_count), 36'd0);

        // single 4-beat packet on inp1
        outq.delete(); gorder.delete();
        @(posedge clk); push_pkt(1, 4, 32'h1000);
        @(negedge clk); chk("t1_bubble", 36'(grant), 36'd3);
        @(negedge clk); chk("t1_grant", 36'(grant), 36'd1);
        wait_done("t1", 1'b0);
        chk("t1_nbeats", 36'(outq.size()), 36'd4);
        for (int i = 0; i < 4 && i < outq.size(); i++)
            chk("t1_beat", outq[i], beat(i == 0, i == 3, 32'h1000 + 32'(i)));
        chk("t1_pkt", 36'(pkt_count), 36'd1);

        // round-robin, all three inputs busy
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        outq.delete(); gorder.delete(); b0 = busy;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            push_pkt(i, 2, 32'h2000 + 32'(i * 16));
            push_pkt(i, 2, 32'h2008 + 32'(i * 16));
        end
        wait_done("t2", 1'b0);
        chk_order("t2_order", 2'd0, 2'd1, 2'd2, 6);
        chk("t2_cycles", 36'(busy - b0), 36'd18);
        chk("t2_pkt", 36'(pkt_count), 36'd7);

        // strict priority
        wr(8'd0, 32'h0000_0107);
        gorder.delete();
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            push_pkt(i, 2, 32'h3000 + 32'(i * 16));
            push_pkt(i, 2, 32'h3008 + 32'(i * 16));
        end
        wait_done("t3", 1'b0);
        chk("t3_len", 36'(gorder.size()), 36'd6);
        for (int i = 0; i < 6 && i < gorder.size(); i++) chk("t3_order", 36'(gorder[i]), 36'(i / 2));
        wr(8'd0, 32'h0000_0007);

        // orphans on inp2 then a good packet
        outq.delete();
        @(posedge clk);
        for (int i = 0; i < 3; i++) q2.push_back(beat(1'b0, 1'b0, 32'hDEAD_0000 + 32'(i)));
        push_pkt(2, 2, 32'h4000);
        wait_done("t4", 1'b0);
        chk("t4_drop", 36'(drop_count), 36'd3);
        chk("t4_nbeats", 36'(outq.size()), 36'd2);
        for (int i = 0; i < 2 && i < outq.size(); i++)
            chk("t4_beat", outq[i], beat(i == 0, i == 1, 32'h4000 + 32'(i)));

        // mask inp0 off in the middle of its packet
        gorder.delete();
        @(posedge clk); push_pkt(0, 4, 32'h5000);
        for (int c = 0; c < 20 && grant != 2'd0; c++) @(negedge clk);
        wr(8'd0, 32'h0000_0006);
        push_pkt(0, 2, 32'h5100);
        push_pkt(1, 2, 32'h5200);
        push_pkt(2, 2, 32'h5300);
        wait_done("t5", 1'b1);
        chk_order("t5_order", 2'd0, 2'd1, 2'd2, 3);
        chk("t5_left", 36'(q0.size()), 36'd2);
        chk("t5_pkt", 36'(pkt_count), 36'd17);
        @(posedge clk); q0.delete();
        wr(8'd0, 32'h0000_0007);

        // backpressure toggling
        outq.delete(); toggle_rdy = 1'b1;
        @(posedge clk); push_pkt(1, 4, 32'h6000);
        wait_done("t6", 1'b0);
        toggle_rdy = 1'b0;
        chk("t6_nbeats", 36'(outq.size()), 36'd4);
        for (int i = 0; i < 4 && i < outq.size(); i++)
            chk("t6_beat", outq[i], beat(i == 0, i == 3, 32'h6000 + 32'(i)));

        // reset mid-packet
        @(posedge clk); push_pkt(2, 4, 32'h7000);
        for (int c = 0; c < 20 && !(outp.valid && grant == 2'd2); c++) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1; q2.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_grant", 36'(grant), 36'd3);
        chk("t6_rst_pkt", 36'(pkt_count), 36'd0);
        chk("t6_rst_drop", 36'(drop_count), 36'd0);

        // one-beat packet, then counter clear
        @(posedge clk); push_pkt(0, 1, 32'h8000);
        wait_done("t7", 1'b0);
        chk("t7_pkt", 36'(pkt_count), 36'd1);
        wr(8'd1, 32'h0);
        @(negedge clk);
        chk("t7_clr_pkt", 36'(pkt_count), 36'd0);
        chk("t7_clr_drop", 36'(drop_count), 36'd0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/packet_arbiter36_x3.md
Name: packet_arbiter36_x3

Overview:
- Packet-granular arbiter that merges three fifo36 streams into one fifo36 output.
- Sits ahead of the Ethernet TX path and shares it between the CPU TX stream, the external-port return stream and the DSP RX stream.
- Never interleaves packets: a grant is held from the SOF beat through the EOF beat.
- Programmable via setting registers (enable mask, scheduling mode); keeps packet and drop counters for the CPU.

Parameters:
- BASE, 0, setting-register base address (BASE+0 = control, BASE+1 = counter clear).
- EN_RESET, 3'b111, reset value of the per-input enable mask.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- clr  in  1  sync clear: state and grant only, registers untouched
- set_stb  in  1  setting strobe
- set_addr  in  8  setting address
- set_data  in  32  setting data
- inpN_data  in  36  N=0..2; fifo36 beat ([32] SOF, [33] EOF, [35:34] occupancy)
- inpN_valid  in  1  N=0..2
- inpN_ready  out  1  N=0..2
- out_data  out  36  merged stream
- out_valid  out  1  merged stream valid
- out_ready  in  1  merged stream ready
- grant  out  2  current owner 0..2; 3 = none
- pkt_count  out  16  packets forwarded (EOF transfers), wraps
- drop_count  out  16  orphan beats discarded, saturates at 16'hFFFF

Behaviour:
- Control register (BASE+0):
  - [2:0] enable mask; reset EN_RESET.
  - [8] strict mode; reset 0.
- Write to BASE+1 zeroes both counters on the following cycle.
- States:
  - IDLE: no grant, grant=3, out_valid=0.
  - PASS: grant held.
- IDLE candidate:
  - A candidate is an input with valid=1, data[32]=1 and its enable bit set.
  - Round-robin mode: search starts at last+1 mod 3.
  - Strict mode: fixed order 0 > 1 > 2.
  - On a candidate, register grant and go to PASS next cycle. The SOF beat is not consumed in IDLE (ready=0), giving a 1-cycle bubble per packet.
- Orphan discard in IDLE:
  - An enabled input with valid=1 and SOF=0 gets ready=1; the beat is discarded and drop_count increments.
  - Simultaneous discards on several inputs in one cycle count 1 each, summed and saturated.
- PASS:
  - out_data = inp[grant]_data, out_valid = inp[grant]_valid, inp[grant]_ready = out_ready. Purely combinational, zero latency.
  - Other inputs: ready=0.
- Leaving PASS:
  - Transfer (out_valid & out_ready) with EOF=1 → IDLE; last <= grant; pkt_count +1 (wraps 16'hFFFF→0).
  - A single beat with SOF=EOF=1 is a complete one-beat packet.
- Enable bit cleared while its input owns the grant: the current packet completes and no new grant is given to that input.
- Counter clear in the same cycle as an increment: the clear wins.
- Reset:
  - State IDLE, grant=3, last=2 (input 0 first), counters 0, mask EN_RESET, strict 0.
  - out_valid=0, all inpN_ready=0 until the first IDLE evaluation. IDLE discard readies are combinational, so they may assert in the cycle after reset deasserts.
  - Reset mid-packet abandons the packet; the downstream consumer must tolerate the truncated packet.
- clr: same as reset for state, grant and last; registers and counters keep their values.

Test Plan:
- Single packet on inp1 (4 beats, SOF on beat 0, EOF on beat 3), out_ready=1 → grant=1 one cycle after valid, 4 output beats identical to input, pkt_count=1, then grant=3.
- All three inputs hold 2-beat packets continuously, round-robin mode → grant order 0,1,2,0,1,2; 6 packets take 18 cycles; no interleaving.
- Same stimulus with strict mode=1 → only input 0 is served while it keeps offering packets; inputs 1 and 2 get ready=0 throughout.
- Orphan beats: inp2 sends 3 beats with SOF=0 while IDLE, followed by a valid packet → drop_count=3, then the packet forwards intact.
- Mask write 3'b110 during an inp0 packet → that packet completes; later inp0 packets are never granted and inputs 1 and 2 proceed.
- out_ready toggling 1,0,1,0 during a packet, rst asserted mid-packet, then a write to BASE+1 → no beat is lost or duplicated under backpressure; after rst grant=3, counters 0; after the BASE+1 write counters read 0.
